// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stage-register control: load-use interlock, multi-cycle EX sequencing,
// memory-busy freeze, redirect flush, saturating perf counters and a memory-timeout flag.
module pipe_hazard_ctrl #(
    parameter int unsigned MC_LAT  = 4,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             ex_RMEM,
    input  logic             ex_WREG,
    input  logic [4:0]       ex_nd,
    input  logic             ex_mc_start,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    output logic             pc_CE,
    output logic             ifid_CE,
    output logic             ifid_flush,
    output logic             idex_CE,
    output logic             idex_flush,
    output logic             exmem_CE,
    output logic             mc_done,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic             mem_timeout_err
);

    localparam int unsigned McCntW = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
    localparam int unsigned RunW   = $clog2(TIMEOUT + 1);

    localparam logic [McCntW-1:0] McLoad = McCntW'(MC_LAT - 1);
    localparam logic [RunW-1:0]   RunMax = RunW'(TIMEOUT);

    typedef enum logic [0:0] {
        StRun,
        StMcBusy
    } state_e;

    state_e              state_q, state_d;
    logic [McCntW-1:0]   mc_cnt_q, mc_cnt_d;
    logic [CNT_W-1:0]    stall_q, stall_d;
    logic [CNT_W-1:0]    flush_q, flush_d;
    logic [RunW-1:0]     run_q, run_d;
    logic                err_q, err_d;

    logic                load_use;
    logic                rs_hit;
    logic                rt_hit;
    logic                freeze;
    logic                redirect_acc;

    // ------------------------------------------------------------------
    // Load-use hazard between ID and EX
    // ------------------------------------------------------------------
    always_comb begin
        rs_hit   = id_use_rs && (id_rs == ex_nd);
        rt_hit   = id_use_rt && (id_rt == ex_nd);
        load_use = ex_RMEM && ex_WREG && (ex_nd != 5'd0) && (rs_hit || rt_hit);
    end

    // ------------------------------------------------------------------
    // Multi-cycle FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StRun;
            mc_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            mc_cnt_q <= mc_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Multi-cycle FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        mc_cnt_d = mc_cnt_q;
        unique case (state_q)
            StRun: begin
                if (ex_mc_start && !mem_busy) begin
                    state_d  = StMcBusy;
                    mc_cnt_d = McLoad;
                end
            end
            StMcBusy: begin
                // mem_busy holds the countdown where it is
                if (!mem_busy) begin
                    if (mc_cnt_q != '0) begin
                        mc_cnt_d = mc_cnt_q - McCntW'(1);
                    end else begin
                        state_d = StRun;
                    end
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Multi-cycle FSM: outputs and pipeline controls
    // ------------------------------------------------------------------
    always_comb begin
        freeze  = mem_busy;
        mc_done = 1'b0;
        unique case (state_q)
            StRun: begin
                freeze = freeze || ex_mc_start;
            end
            StMcBusy: begin
                freeze  = freeze || (mc_cnt_q != '0);
                mc_done = (mc_cnt_q == '0) && !mem_busy;
            end
        endcase

        redirect_acc = ex_redirect && !freeze;

        pc_CE      = 1'b1;
        ifid_CE    = 1'b1;
        ifid_flush = 1'b0;
        idex_CE    = 1'b1;
        idex_flush = 1'b0;
        exmem_CE   = 1'b1;

        if (freeze) begin
            pc_CE    = 1'b0;
            ifid_CE  = 1'b0;
            idex_CE  = 1'b0;
            exmem_CE = 1'b0;
        end else if (redirect_acc) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            // hold PC and IF/ID, inject a bubble into ID/EX
            pc_CE      = 1'b0;
            ifid_CE    = 1'b0;
            idex_flush = 1'b1;
        end

        if (rst) begin
            pc_CE        = 1'b0;
            ifid_CE      = 1'b0;
            ifid_flush   = 1'b1;
            idex_CE      = 1'b0;
            idex_flush   = 1'b1;
            exmem_CE     = 1'b0;
            mc_done      = 1'b0;
            redirect_acc = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Performance counters and memory timeout
    // ------------------------------------------------------------------
    always_comb begin
        stall_d = stall_q;
        if (!pc_CE && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end

        flush_d = flush_q;
        if (redirect_acc && (flush_q != '1)) begin
            flush_d = flush_q + CNT_W'(1);
        end

        run_d = '0;
        if (mem_busy) begin
            run_d = (run_q == RunMax) ? run_q : run_q + RunW'(1);
        end

        err_d = err_q || (run_d == RunMax);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
            run_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
            run_q   <= run_d;
            err_q   <= err_d;
        end
    end

    assign stall_cycles    = stall_q;
    assign flush_count     = flush_q;
    assign mem_timeout_err = err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: expected control vectors are queued as stimulus
// is applied and compared at the falling edge; counters are checked against fixed values.
module tb_pipe_hazard_ctrl;

    localparam int unsigned MC_LAT  = 4;
    localparam int unsigned TIMEOUT = 8;
    localparam int unsigned CNT_W   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rs, id_rt, ex_nd;
    logic             id_use_rs, id_use_rt, ex_RMEM, ex_WREG;
    logic             ex_mc_start, ex_redirect, mem_busy;
    logic             pc_CE, ifid_CE, ifid_flush, idex_CE, idex_flush, exmem_CE, mc_done;
    logic [CNT_W-1:0] stall_cycles, flush_count;
    logic             mem_timeout_err;

    pipe_hazard_ctrl #(
        .MC_LAT (MC_LAT),
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_use_rs      (id_use_rs),
        .id_use_rt      (id_use_rt),
        .ex_RMEM        (ex_RMEM),
        .ex_WREG        (ex_WREG),
        .ex_nd          (ex_nd),
        .ex_mc_start    (ex_mc_start),
        .ex_redirect    (ex_redirect),
        .mem_busy       (mem_busy),
        .pc_CE          (pc_CE),
        .ifid_CE        (ifid_CE),
        .ifid_flush     (ifid_flush),
        .idex_CE        (idex_CE),
        .idex_flush     (idex_flush),
        .exmem_CE       (exmem_CE),
        .mc_done        (mc_done),
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count),
        .mem_timeout_err(mem_timeout_err)
    );

    always #5 clk = ~clk;

    // {pc_CE, ifid_CE, ifid_flush, idex_CE, idex_flush, exmem_CE, mc_done}
    typedef logic [6:0] ctl_t;
    localparam ctl_t NORM     = 7'b1101010;
    localparam ctl_t FRZ      = 7'b0000000;
    localparam ctl_t RDR      = 7'b1111110;
    localparam ctl_t LU       = 7'b0001110;
    localparam ctl_t RSTV     = 7'b0010100;
    localparam ctl_t DONE     = 7'b1101011;
    localparam ctl_t RDR_DONE = 7'b1111111;

    typedef struct {
        logic start;
        logic busy;
        logic redir;
        logic haz;
        ctl_t exp;
    } step_t;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic       rmem;
        logic       wreg;
        logic [4:0] nd;
        ctl_t       exp;
    } lu_t;

    ctl_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic ctl_t ctl();
        return {pc_CE, ifid_CE, ifid_flush, idex_CE, idex_flush, exmem_CE, mc_done};
    endfunction

    task automatic set_idle();
        id_rs       = 5'd0;
        id_rt       = 5'd0;
        id_use_rs   = 1'b0;
        id_use_rt   = 1'b0;
        ex_RMEM     = 1'b0;
        ex_WREG     = 1'b0;
        ex_nd       = 5'd0;
        ex_mc_start = 1'b0;
        ex_redirect = 1'b0;
        mem_busy    = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        set_idle();
        tick();
        rst = 1'b0;
    endtask

    // Drives one cycle of stimulus and queues its expected control vector.
    task automatic drive_step(input step_t s);
        set_idle();
        ex_mc_start = s.start;
        mem_busy    = s.busy;
        ex_redirect = s.redir;
        if (s.haz) begin
            ex_RMEM   = 1'b1;
            ex_WREG   = 1'b1;
            ex_nd     = 5'd5;
            id_rs     = 5'd5;
            id_use_rs = 1'b1;
        end
        exp_q.push_back(s.exp);
    endtask

    task automatic test_reset();
        ctl_t e;
        rst = 1'b1;
        set_idle();
        exp_q.push_back(RSTV);
        @(negedge clk);
        e = exp_q.pop_front();
        n_total++;
        if (ctl() !== e) $display("FAIL reset_ctl: got %b expected %b", ctl(), e);
        else n_pass++;
        n_total++;
        if (stall_cycles !== 4'd0 || flush_count !== 4'd0 || mem_timeout_err !== 1'b0)
            $display("FAIL reset_cnt: got stall=%0d flush=%0d err=%b expected 0/0/0",
                     stall_cycles, flush_count, mem_timeout_err);
        else n_pass++;
        tick();
        rst = 1'b0;

        exp_q.push_back(NORM);
        @(negedge clk);
        e = exp_q.pop_front();
        n_total++;
        if (ctl() !== e) $display("FAIL idle_ctl: got %b expected %b", ctl(), e);
        else n_pass++;
        n_total++;
        if (stall_cycles !== 4'd0 || flush_count !== 4'd0)
            $display("FAIL idle_cnt: got stall=%0d flush=%0d expected 0/0",
                     stall_cycles, flush_count);
        else n_pass++;
        tick();

        drive_step('{1'b0, 1'b0, 1'b0, 1'b1, LU});
        @(negedge clk);
        e = exp_q.pop_front();
        n_total++;
        if (ctl() !== e) $display("FAIL pre_async_ctl: got %b expected %b", ctl(), e);
        else n_pass++;
        tick();
        set_idle();
        @(negedge clk);
        n_total++;
        if (stall_cycles !== 4'd1) $display("FAIL pre_async_stall: got %0d expected 1", stall_cycles);
        else n_pass++;
        #1 rst = 1'b1;
        #1;
        n_total++;
        if (ctl() !== RSTV) $display("FAIL async_rst_ctl: got %b expected %b", ctl(), RSTV);
        else n_pass++;
        n_total++;
        if (stall_cycles !== 4'd0) $display("FAIL async_rst_stall: got %0d expected 0", stall_cycles);
        else n_pass++;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_load_use();
        lu_t  c[$];
        ctl_t e;
        apply_reset();
        c.push_back('{5'd5, 5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 5'd5,  LU});
        c.push_back('{5'd0, 5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 5'd0,  NORM});
        c.push_back('{5'd2, 5'd7,  1'b0, 1'b1, 1'b1, 1'b1, 5'd7,  LU});
        c.push_back('{5'd2, 5'd7,  1'b0, 1'b0, 1'b1, 1'b1, 5'd7,  NORM});
        c.push_back('{5'd9, 5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 5'd9,  NORM});
        c.push_back('{5'd3, 5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 5'd3,  NORM});
        c.push_back('{5'd1, 5'd31, 1'b1, 1'b1, 1'b1, 1'b1, 5'd31, LU});
        c.push_back('{5'd4, 5'd6,  1'b1, 1'b1, 1'b1, 1'b1, 5'd8,  NORM});
        foreach (c[i]) begin
            set_idle();
            id_rs     = c[i].rs;
            id_rt     = c[i].rt;
            id_use_rs = c[i].use_rs;
            id_use_rt = c[i].use_rt;
            ex_RMEM   = c[i].rmem;
            ex_WREG   = c[i].wreg;
            ex_nd     = c[i].nd;
            exp_q.push_back(c[i].exp);
            @(negedge clk);
            e = exp_q.pop_front();
            n_total++;
            if (ctl() !== e) $display("FAIL load_use[%0d]: got %b expected %b", i, ctl(), e);
            else n_pass++;
            tick();
        end
        set_idle();
        @(negedge clk);
        n_total++;
        if (stall_cycles !== 4'd3) $display("FAIL load_use_stall: got %0d expected 3", stall_cycles);
        else n_pass++;
        tick();
    endtask

    task automatic test_multicycle();
        step_t s[$];
        ctl_t  e;
        apply_reset();
        s.push_back('{1'b1, 1'b0, 1'b0, 1'b0, FRZ});
        for (int k = 0; k < 3; k++) s.push_back('{1'b0, 1'b0, 1'b0, 1'b0, FRZ});
        s.push_back('{1'b0, 1'b0, 1'b0, 1'b0, DONE});
        s.push_back('{1'b0, 1'b0, 1'b0, 1'b0, NORM});
        foreach (s[i]) begin
            drive_step(s[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_total++;
            if (ctl() !== e) $display("FAIL mc[%0d]: got %b expected %b", i, ctl(), e);
            else n_pass++;
            if (i == 5) begin
                n_total++;
                if (stall_cycles !== 4'd4) $display("FAIL mc_stall: got %0d expected 4", stall_cycles);
                else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_mc_mem_busy();
        step_t s[$];
        ctl_t  e;
        apply_reset();
        s.push_back('{1'b1, 1'b0, 1'b0, 1'b0, FRZ});
        s.push_back('{1'b0, 1'b0, 1'b0, 1'b0, FRZ});
        s.push_back('{1'b0, 1'b1, 1'b0, 1'b0, FRZ});
        s.push_back('{1'b0, 1'b1, 1'b0, 1'b0, FRZ});
        s.push_back('{1'b0, 1'b0, 1'b0, 1'b0, FRZ});
        s.push_back('{1'b0, 1'b0, 1'b0, 1'b0, FRZ});
        s.push_back('{1'b0, 1'b0, 1'b0, 1'b0, DONE});
        s.push_back('{1'b0, 1'b0, 1'b0, 1'b0, NORM});
        foreach (s[i]) begin
            drive_step(s[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_total++;
            if (ctl() !== e) $display("FAIL mc_busy[%0d]: got %b expected %b", i, ctl(), e);
            else n_pass++;
            if (i == 7) begin
                n_total++;
                if (stall_cycles !== 4'd6) $display("FAIL mc_busy_stall: got %0d expected 6", stall_cycles);
                else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_redirect();
        step_t s[$];
        ctl_t  e;
        apply_reset();
        s.push_back('{1'b0, 1'b0, 1'b1, 1'b1, RDR});      // 0: redirect beats load-use
        s.push_back('{1'b0, 1'b0, 1'b0, 1'b0, NORM});     // 1
        s.push_back('{1'b0, 1'b1, 1'b1, 1'b0, FRZ});      // 2: redirect ignored under mem_busy
        s.push_back('{1'b0, 1'b0, 1'b0, 1'b0, NORM});     // 3
        s.push_back('{1'b1, 1'b0, 1'b0, 1'b0, FRZ});      // 4: mc start
        s.push_back('{1'b0, 1'b0, 1'b1, 1'b0, FRZ});      // 5..7: redirect ignored in MC_BUSY
        s.push_back('{1'b0, 1'b0, 1'b1, 1'b0, FRZ});
        s.push_back('{1'b0, 1'b0, 1'b1, 1'b0, FRZ});
        s.push_back('{1'b0, 1'b0, 1'b1, 1'b0, RDR_DONE}); // 8: done and redirect together
        s.push_back('{1'b0, 1'b0, 1'b0, 1'b0, NORM});     // 9
        foreach (s[i]) begin
            drive_step(s[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_total++;
            if (ctl() !== e) $display("FAIL redirect[%0d]: got %b expected %b", i, ctl(), e);
            else n_pass++;
            if (i == 1 || i == 3 || i == 7) begin
                n_total++;
                if (flush_count !== 4'd1)
                    $display("FAIL redirect_cnt[%0d]: got %0d expected 1", i, flush_count);
                else n_pass++;
            end
            if (i == 9) begin
                n_total++;
                if (flush_count !== 4'd2) $display("FAIL redirect_cnt_end: got %0d expected 2", flush_count);
                else n_pass++;
                n_total++;
                if (stall_cycles !== 4'd5) $display("FAIL redirect_stall: got %0d expected 5", stall_cycles);
                else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        step_t s[$];
        ctl_t  e;
        apply_reset();
        // ex_mc_start held high: ignored in MC_BUSY, restarts once back in RUN
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 4; j++) s.push_back('{1'b1, 1'b0, 1'b0, 1'b0, FRZ});
            s.push_back('{1'b1, 1'b0, 1'b0, 1'b0, DONE});
        end
        s.push_back('{1'b0, 1'b0, 1'b0, 1'b0, NORM});
        foreach (s[i]) begin
            drive_step(s[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_total++;
            if (ctl() !== e) $display("FAIL b2b[%0d]: got %b expected %b", i, ctl(), e);
            else n_pass++;
            if (i == 10) begin
                n_total++;
                if (stall_cycles !== 4'd8) $display("FAIL b2b_stall: got %0d expected 8", stall_cycles);
                else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_mc();
        ctl_t e;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive_step('{(i == 0), 1'b0, 1'b0, 1'b0, FRZ});
            @(negedge clk);
            e = exp_q.pop_front();
            n_total++;
            if (ctl() !== e) $display("FAIL rst_mc[%0d]: got %b expected %b", i, ctl(), e);
            else n_pass++;
            if (i < 2) tick();
        end
        #1 rst = 1'b1;
        #1;
        n_total++;
        if (ctl() !== RSTV) $display("FAIL rst_mc_async: got %b expected %b", ctl(), RSTV);
        else n_pass++;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_step('{1'b0, 1'b0, 1'b0, 1'b0, NORM});
            @(negedge clk);
            e = exp_q.pop_front();
            n_total++;
            if (ctl() !== e) $display("FAIL rst_mc_after[%0d]: got %b expected %b", i, ctl(), e);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_timeout();
        ctl_t e;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            drive_step('{1'b0, (i < 7), 1'b0, 1'b0, (i < 7) ? FRZ : NORM});
            @(negedge clk);
            e = exp_q.pop_front();
            n_total++;
            if (ctl() !== e) $display("FAIL tmo7[%0d]: got %b expected %b", i, ctl(), e);
            else n_pass++;
            if (i == 7) begin
                n_total++;
                if (mem_timeout_err !== 1'b0) $display("FAIL tmo7_err: got %b expected 0", mem_timeout_err);
                else n_pass++;
            end
            tick();
        end
        for (int i = 0; i < 11; i++) begin
            drive_step('{1'b0, (i < 8), 1'b0, 1'b0, (i < 8) ? FRZ : NORM});
            @(negedge clk);
            e = exp_q.pop_front();
            n_total++;
            if (ctl() !== e) $display("FAIL tmo8[%0d]: got %b expected %b", i, ctl(), e);
            else n_pass++;
            if (i == 7) begin
                n_total++;
                if (mem_timeout_err !== 1'b0) $display("FAIL tmo8_err_early: got %b expected 0", mem_timeout_err);
                else n_pass++;
            end
            if (i >= 8) begin
                n_total++;
                if (mem_timeout_err !== 1'b1)
                    $display("FAIL tmo8_err[%0d]: got %b expected 1", i, mem_timeout_err);
                else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_saturation();
        ctl_t e;
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            drive_step('{1'b0, 1'b0, 1'b0, 1'b1, LU});
            @(negedge clk);
            e = exp_q.pop_front();
            if (i == 0 || i == 19) begin
                n_total++;
                if (ctl() !== e) $display("FAIL sat_lu[%0d]: got %b expected %b", i, ctl(), e);
                else n_pass++;
            end
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            drive_step('{1'b0, 1'b0, 1'b1, 1'b0, RDR});
            @(negedge clk);
            e = exp_q.pop_front();
            if (i == 0) begin
                n_total++;
                if (stall_cycles !== 4'd15) $display("FAIL sat_stall: got %0d expected 15", stall_cycles);
                else n_pass++;
            end
            if (i == 19) begin
                n_total++;
                if (ctl() !== e) $display("FAIL sat_rdr: got %b expected %b", ctl(), e);
                else n_pass++;
            end
            tick();
        end
        set_idle();
        @(negedge clk);
        n_total++;
        if (flush_count !== 4'd15) $display("FAIL sat_flush: got %0d expected 15", flush_count);
        else n_pass++;
        n_total++;
        if (stall_cycles !== 4'd15) $display("FAIL sat_stall_hold: got %0d expected 15", stall_cycles);
        else n_pass++;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        set_idle();
        #1;
        test_reset();
        test_load_use();
        test_multicycle();
        test_mc_mem_busy();
        test_redirect();
        test_back_to_back();
        test_reset_mid_mc();
        test_timeout();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
